// File: rtl/sine_keystream_gen_if.sv
// Bus bundle between the keystream generator, its run controller, the
// combinational sine map stage and the downstream XOR consumer.
interface sine_keystream_gen_if;
    logic        start;
    logic [31:0] seed;
    logic [31:0] ratio_in;
    logic [23:0] num_bytes;
    logic [31:0] map_x_n;
    logic [31:0] map_ratio;
    logic [31:0] map_x_next;
    logic [7:0]  ks_byte;
    logic        ks_valid;
    logic        ks_ready;
    logic        busy;
    logic        done;

    modport slave (
        input  start, seed, ratio_in, num_bytes, map_x_next, ks_ready,
        output map_x_n, map_ratio, ks_byte, ks_valid, busy, done
    );

    modport master (
        output start, seed, ratio_in, num_bytes, map_x_next, ks_ready,
        input  map_x_n, map_ratio, ks_byte, ks_valid, busy, done
    );
endinterface

// File: rtl/sine_keystream_gen.sv
// Drives the sine map iteration: loads a seed, discards a warm-up transient,
// then emits one keystream byte per further iteration over valid/ready.
module sine_keystream_gen #(
    parameter int unsigned DISCARD     = 1000,
    parameter int unsigned MAP_LATENCY = 1,
    parameter logic [31:0] ZERO_SUB    = 32'h9E3779B9
) (
    input  logic                 clk,
    input  logic                 rst,
    sine_keystream_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WARM = 3'd1,
        ST_EMIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [15:0] DISC_INIT = 16'(DISCARD);
    localparam logic [3:0]  LAT_LAST  = 4'(MAP_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_x;
    logic [31:0] r_ratio;
    logic [31:0] r_saved_seed;
    logic [23:0] r_bytes_left;
    logic [15:0] r_disc_cnt;
    logic [3:0]  r_lat_cnt;
    logic [7:0]  r_ks_byte;
    logic        r_ks_valid;
    logic        r_busy;
    logic        r_done;

    logic        w_lat_run;
    logic        w_lat_hit;
    logic        w_handshake;
    logic [31:0] w_cap;
    logic [31:0] w_seed_load;

    // Iteration strobe, zero-collapse guards and handshake qualifier
    always_comb begin
        w_lat_run   = (r_state == ST_WARM) || (r_state == ST_EMIT);
        w_lat_hit   = w_lat_run && (r_lat_cnt == LAT_LAST);
        w_handshake = r_ks_valid && bus.ks_ready;
        if (bus.map_x_next == 32'd0) begin
            w_cap = r_saved_seed ^ ZERO_SUB;
        end else begin
            w_cap = bus.map_x_next;
        end
        if (bus.seed == 32'd0) begin
            w_seed_load = ZERO_SUB;
        end else begin
            w_seed_load = bus.seed;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!bus.start) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.num_bytes == 24'd0) begin
                    w_state_nxt = ST_DONE;
                end else if (DISC_INIT == 16'd0) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_state_nxt = ST_WARM;
                end
            end
            ST_WARM: begin
                // The capture that takes the counter from one to zero ends warm-up
                if (w_lat_hit && (r_disc_cnt <= 16'd1)) begin
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_state_nxt = ST_WARM;
                end
            end
            ST_EMIT: begin
                if (w_lat_hit) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_HOLD: begin
                if (!w_handshake) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_bytes_left <= 24'd1) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_x          <= 32'd0;
            r_ratio      <= 32'd0;
            r_saved_seed <= 32'd0;
            r_bytes_left <= 24'd0;
            r_disc_cnt   <= 16'd0;
            r_lat_cnt    <= 4'd0;
            r_ks_byte    <= 8'd0;
            r_ks_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
            // Latency counter restarts at every capture and outside the iterating states
            if (w_lat_run && !w_lat_hit) begin
                r_lat_cnt <= r_lat_cnt + 4'd1;
            end else begin
                r_lat_cnt <= 4'd0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_x          <= w_seed_load;
                        r_ratio      <= bus.ratio_in;
                        r_saved_seed <= bus.seed;
                        r_bytes_left <= bus.num_bytes;
                        r_disc_cnt   <= DISC_INIT;
                    end
                end
                ST_WARM: begin
                    if (w_lat_hit) begin
                        r_x <= w_cap;
                        if (r_disc_cnt != 16'd0) begin
                            r_disc_cnt <= r_disc_cnt - 16'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_lat_hit) begin
                        r_x        <= w_cap;
                        r_ks_byte  <= w_cap[23:16] ^ w_cap[7:0];
                        r_ks_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_ks_valid <= 1'b0;
                        if (r_bytes_left != 24'd0) begin
                            r_bytes_left <= r_bytes_left - 24'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.map_x_n   = r_x;
    assign bus.map_ratio = r_ratio;
    assign bus.ks_byte   = r_ks_byte;
    assign bus.ks_valid  = r_ks_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
